// File: rtl/sram_access_arbiter.sv
// Two-requester SRAM sequencer: arbitrates CPU and DMA access, generates registered
// active-low SRAM strobes and a one-cycle acknowledge to the granted requester.
module sram_access_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MAX_DEFER   = 4
) (
    input  logic       CLK_ACCEL,
    input  logic       RESET,
    input  logic       CPU_REQ,
    input  logic       CPU_RW,
    input  logic       CPU_UDS_n,
    input  logic       CPU_LDS_n,
    input  logic       CPU_WP,
    output logic       CPU_ACK,
    input  logic       DMA_REQ,
    input  logic       DMA_RW,
    input  logic [1:0] DMA_BE,
    output logic       DMA_ACK,
    output logic       ADDR_SEL,
    output logic       RAM_CE_n,
    output logic       RAM_OE_n,
    output logic       RAM_WR_n,
    output logic       RAM_UB_n,
    output logic       RAM_LB_n,
    output logic       BUSY,
    output logic [1:0] DBG_STATE,
    output logic [3:0] DBG_DEFER
);

    // Handshake: REQ is a level held until its one-cycle ACK; a request is only
    // serviced again after REQ has been seen low (armed flag), and the CPU may
    // withdraw REQ before ACK to abort.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);
    localparam logic [3:0] MD = 4'(MAX_DEFER);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic [3:0] defer_q, defer_d;
    logic       cpu_armed_q, cpu_armed_d;
    logic       dma_armed_q, dma_armed_d;
    logic       addr_sel_q, addr_sel_d;
    logic       rw_q, rw_d;
    logic       wp_q, wp_d;
    logic       ce_n_q, ce_n_d;
    logic       oe_n_q, oe_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ub_n_q, ub_n_d;
    logic       lb_n_q, lb_n_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       dma_ack_q, dma_ack_d;
    logic       cpu_pend, dma_pend, cpu_abort;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        defer_d    = defer_q;
        addr_sel_d = addr_sel_q;
        rw_d       = rw_q;
        wp_d       = wp_q;
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        ub_n_d     = 1'b1;
        lb_n_d     = 1'b1;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;

        cpu_pend  = CPU_REQ && cpu_armed_q;
        dma_pend  = DMA_REQ && dma_armed_q;
        cpu_abort = !addr_sel_q && !CPU_REQ;

        case (state_q)
            IDLE: begin
                if (!dma_pend) defer_d = '0;
                if (dma_pend && (!cpu_pend || defer_q == MD)) begin
                    state_d    = SETUP;
                    addr_sel_d = 1'b1;
                    rw_d       = DMA_RW;
                    wp_d       = 1'b0;
                    ce_n_d     = 1'b0;
                    ub_n_d     = ~DMA_BE[1];
                    lb_n_d     = ~DMA_BE[0];
                    defer_d    = '0;
                end else if (cpu_pend) begin
                    state_d    = SETUP;
                    addr_sel_d = 1'b0;
                    rw_d       = CPU_RW;
                    wp_d       = CPU_WP;
                    ce_n_d     = 1'b0;
                    ub_n_d     = CPU_UDS_n;
                    lb_n_d     = CPU_LDS_n;
                    if (dma_pend && defer_q < MD) defer_d = defer_q + 4'd1;
                end
            end
            SETUP: begin
                if (cpu_abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = STROBE;
                    wait_d  = '0;
                    ce_n_d  = 1'b0;
                    ub_n_d  = ub_n_q;
                    lb_n_d  = lb_n_q;
                    oe_n_d  = ~rw_q;
                    wr_n_d  = rw_q | wp_q;
                end
            end
            STROBE: begin
                if (cpu_abort) begin
                    state_d = IDLE;
                end else begin
                    ce_n_d = 1'b0;
                    ub_n_d = ub_n_q;
                    lb_n_d = lb_n_q;
                    if (wait_q == WS) begin
                        // OE/WR release one cycle ahead of CE/UB/LB for hold time
                        state_d   = DONE;
                        cpu_ack_d = !addr_sel_q;
                        dma_ack_d = addr_sel_q;
                    end else begin
                        wait_d = wait_q + 3'd1;
                        oe_n_d = ~rw_q;
                        wr_n_d = rw_q | wp_q;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cpu_armed_d = cpu_armed_q | ~CPU_REQ;
        if (cpu_ack_d) cpu_armed_d = 1'b0;
        dma_armed_d = dma_armed_q | ~DMA_REQ;
        if (dma_ack_d) dma_armed_d = 1'b0;
    end

    always_ff @(posedge CLK_ACCEL) begin
        if (RESET) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            defer_q     <= '0;
            cpu_armed_q <= 1'b1;
            dma_armed_q <= 1'b1;
            addr_sel_q  <= 1'b0;
            rw_q        <= 1'b1;
            wp_q        <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            defer_q     <= defer_d;
            cpu_armed_q <= cpu_armed_d;
            dma_armed_q <= dma_armed_d;
            addr_sel_q  <= addr_sel_d;
            rw_q        <= rw_d;
            wp_q        <= wp_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            wr_n_q      <= wr_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign CPU_ACK   = cpu_ack_q;
    assign DMA_ACK   = dma_ack_q;
    assign ADDR_SEL  = addr_sel_q;
    assign RAM_CE_n  = ce_n_q;
    assign RAM_OE_n  = oe_n_q;
    assign RAM_WR_n  = wr_n_q;
    assign RAM_UB_n  = ub_n_q;
    assign RAM_LB_n  = lb_n_q;
    assign BUSY      = (state_q != IDLE);
    assign DBG_STATE = state_q;
    assign DBG_DEFER = defer_q;

endmodule
